// File: rtl/crank_decoder_pkg.sv
// rtl/crank_decoder_pkg.sv - shared crank decoder states, phase scaling and gap test
package crank_decoder_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        SEEK_GAP = 2'd1,
        SYNCED   = 2'd2
    } crank_state_e;

    // The ignition/injection timers use the same 1/256-tooth scaling.
    localparam int QUANTA_PER_TOOTH = 256;
    localparam int QUANTA_SHIFT     = 8;

    // More than 1.5x the previous period; 33-bit sum cannot overflow.
    function automatic logic is_gap(input logic        prev_valid,
                                    input logic [31:0] meas,
                                    input logic [31:0] prev_period);
        logic [32:0] limit;
        limit = {1'b0, prev_period} + {2'b00, prev_period[31:1]};
        return prev_valid && ({1'b0, meas} > limit);
    endfunction

endpackage

// File: rtl/crank_decoder_if.sv
// rtl/crank_decoder_if.sv - tooth-event bundle from the crank decoder to the output timers
interface crank_decoder_if;

    logic        trigger;
    logic [15:0] eng_phase;
    logic [15:0] next_tooth_width;
    logic [31:0] tooth_period;
    logic        synced;
    logic [7:0]  sync_loss_cnt;

    modport master (
        output trigger,
        output eng_phase,
        output next_tooth_width,
        output tooth_period,
        output synced,
        output sync_loss_cnt
    );

    modport slave (
        input trigger,
        input eng_phase,
        input next_tooth_width,
        input tooth_period,
        input synced,
        input sync_loss_cnt
    );

endinterface

// File: rtl/crank_edge_in.sv
// rtl/crank_edge_in.sv - crank pin synchroniser, edge select, noise blanking and period counter
module crank_edge_in #(
    parameter bit          EDGE_RISING = 1'b1,
    parameter int          MIN_PERIOD  = 64,
    parameter logic [31:0] STALL_CLKS  = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        crank_in,
    output logic        edge_evt,
    output logic [31:0] meas,
    output logic        stall
);

    logic [2:0]  sync_q;
    logic [31:0] cnt;
    logic        armed;
    logic        raw_edge;
    logic        accept;

    // Until the first accepted edge there is no reference to blank against.
    always_comb begin
        raw_edge = EDGE_RISING ? (sync_q[1] & ~sync_q[2]) : (~sync_q[1] & sync_q[2]);
        accept   = raw_edge && (!armed || (cnt >= 32'(MIN_PERIOD)));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            edge_evt <= 1'b0;
            meas     <= '0;
            stall    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], crank_in};
            edge_evt <= accept;
            meas     <= cnt;
            stall    <= !accept && (cnt == STALL_CLKS);
            if (accept) begin
                armed <= 1'b1;
                cnt   <= 32'd1;
            end else if (cnt < STALL_CLKS) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/crank_decoder.sv
// rtl/crank_decoder.sv - missing-tooth crank wheel decoder: sync FSM, tooth index, tooth-event outputs
module crank_decoder
    import crank_decoder_pkg::*;
#(
    parameter int          TEETH_TOTAL   = 36,
    parameter int          TEETH_MISSING = 1,
    parameter bit          EDGE_RISING   = 1'b1,
    parameter int          MIN_PERIOD    = 64,
    parameter logic [31:0] STALL_CLKS    = 32'd50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            crank_in,
    crank_decoder_if.master evt
);

    localparam int IDX_W = $clog2(TEETH_TOTAL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEETH_TOTAL - TEETH_MISSING - 1);

    logic        edge_evt;
    logic [31:0] meas;
    logic        stall;

    crank_edge_in #(
        .EDGE_RISING (EDGE_RISING),
        .MIN_PERIOD  (MIN_PERIOD),
        .STALL_CLKS  (STALL_CLKS)
    ) u_edge_in (
        .clk      (clk),
        .reset_n  (reset_n),
        .crank_in (crank_in),
        .edge_evt (edge_evt),
        .meas     (meas),
        .stall    (stall)
    );

    crank_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc, emit_idx;
    logic [31:0]      prev_period_q, prev_period_d;
    logic             prev_valid_q, prev_valid_d;
    logic             trigger_q, trigger_d;
    logic [15:0]      phase_q, phase_d;
    logic [15:0]      width_q, width_d;
    logic [31:0]      period_q, period_d;
    logic [7:0]       loss_q, loss_d;
    logic             gap, expect_gap, emit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= STOPPED;
            idx_q         <= '0;
            prev_period_q <= '0;
            prev_valid_q  <= 1'b0;
            trigger_q     <= 1'b0;
            phase_q       <= '0;
            width_q       <= '0;
            period_q      <= '0;
            loss_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            prev_period_q <= prev_period_d;
            prev_valid_q  <= prev_valid_d;
            trigger_q     <= trigger_d;
            phase_q       <= phase_d;
            width_q       <= width_d;
            period_q      <= period_d;
            loss_q        <= loss_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        prev_period_d = prev_period_q;
        prev_valid_d  = prev_valid_q;
        trigger_d     = 1'b0;
        phase_d       = phase_q;
        width_d       = width_q;
        period_d      = period_q;
        loss_d        = loss_q;
        emit          = 1'b0;

        gap        = is_gap(prev_valid_q, meas, prev_period_q);
        expect_gap = (idx_q == LAST_IDX);
        idx_inc    = expect_gap ? '0 : idx_q + IDX_W'(1);
        emit_idx   = idx_inc;

        // An accepted edge always beats a timeout landing in the same cycle.
        if (edge_evt) begin
            case (state_q)
                STOPPED: begin
                    state_d      = SEEK_GAP;
                    prev_valid_d = 1'b0;
                end
                SEEK_GAP: begin
                    prev_period_d = meas;
                    prev_valid_d  = 1'b1;
                    if (gap) begin
                        state_d  = SYNCED;
                        idx_d    = '0;
                        emit     = 1'b1;
                        emit_idx = '0;
                    end
                end
                SYNCED: begin
                    prev_period_d = meas;
                    if (gap == expect_gap) begin
                        idx_d = idx_inc;
                        emit  = 1'b1;
                    end else begin
                        state_d = SEEK_GAP;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                default: state_d = STOPPED;
            endcase
        end else if (stall) begin
            state_d  = STOPPED;
            period_d = '0;
        end

        // The gap spans two tooth pitches, so its period is halved for the timers.
        if (emit) begin
            trigger_d = 1'b1;
            phase_d   = 16'(emit_idx) << QUANTA_SHIFT;
            width_d   = (emit_idx == LAST_IDX) ? 16'(2 * QUANTA_PER_TOOTH) : 16'(QUANTA_PER_TOOTH);
            period_d  = gap ? (meas >> 1) : meas;
        end
    end

    assign evt.trigger          = trigger_q;
    assign evt.eng_phase        = phase_q;
    assign evt.next_tooth_width = width_q;
    assign evt.tooth_period     = period_q;
    assign evt.synced           = (state_q == SYNCED);
    assign evt.sync_loss_cnt    = loss_q;

endmodule

// File: tb/tb_crank_decoder.sv
// tb/tb_crank_decoder.sv - directed bench for crank_decoder on a scaled 36-1 wheel
module tb_crank_decoder;

    localparam int P = 100;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic crank   = 1'b0;
    logic crank2  = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    crank_decoder_if ev ();
    crank_decoder_if ev2 ();

    crank_decoder #(
        .TEETH_TOTAL   (36),
        .TEETH_MISSING (1),
        .EDGE_RISING   (1'b1),
        .MIN_PERIOD    (64),
        .STALL_CLKS    (32'd5000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .crank_in (crank),
        .evt      (ev)
    );

    crank_decoder #(
        .TEETH_TOTAL   (36),
        .TEETH_MISSING (1),
        .EDGE_RISING   (1'b1),
        .MIN_PERIOD    (4),
        .STALL_CLKS    (32'd5000)
    ) dut_sat (
        .clk      (clk),
        .reset_n  (reset_n),
        .crank_in (crank2),
        .evt      (ev2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rising edge now; outcome visible 4 negedges later; next edge wait_after clks after this one.
    task automatic tooth(input int wait_after, input logic e_trig, input int e_phase,
                         input int e_width, input int e_period, input logic e_synced,
                         input int e_loss, input string tag);
        crank = 1'b1;
        repeat (4) @(negedge clk);
        crank = 1'b0;
        check({tag, ".trigger"}, 32'(ev.trigger), 32'(e_trig));
        check({tag, ".synced"}, 32'(ev.synced), 32'(e_synced));
        check({tag, ".loss"}, 32'(ev.sync_loss_cnt), e_loss);
        if (e_trig) begin
            check({tag, ".phase"}, 32'(ev.eng_phase), e_phase);
            check({tag, ".width"}, 32'(ev.next_tooth_width), e_width);
            check({tag, ".period"}, ev.tooth_period, e_period);
        end
        repeat (wait_after - 4) @(negedge clk);
    endtask

    task automatic resync(input int from_pos, input int e_loss);
        for (int pos = from_pos; pos <= 34; pos++)
            tooth(pos == 34 ? 2 * P : P, 1'b0, 0, 0, 0, 1'b0, e_loss, $sformatf("seek%0d", pos));
        tooth(P, 1'b1, 0, 256, P, 1'b1, e_loss, "resync");
    endtask

    task automatic sat_edge(input int d);
        crank2 = 1'b1;
        repeat (4) @(negedge clk);
        crank2 = 1'b0;
        repeat (d - 4) @(negedge clk);
    endtask

    function automatic int accel_p(input int k);
        return P - ((P / 5) * k) / 70;
    endfunction

    function automatic int accel_w(input int k);
        return (k % 35 == 0) ? 2 * accel_p(k) : accel_p(k);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".trigger"}, 32'(ev.trigger), 0);
        check({tag, ".phase"}, 32'(ev.eng_phase), 0);
        check({tag, ".width"}, 32'(ev.next_tooth_width), 0);
        check({tag, ".period"}, ev.tooth_period, 0);
        check({tag, ".synced"}, 32'(ev.synced), 0);
        check({tag, ".loss"}, 32'(ev.sync_loss_cnt), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Acquire: STOPPED edge, two plain teeth, then the gap.
        tooth(P, 1'b0, 0, 0, 0, 1'b0, 0, "first");
        tooth(P, 1'b0, 0, 0, 0, 1'b0, 0, "seek_a");
        tooth(2 * P, 1'b0, 0, 0, 0, 1'b0, 0, "seek_b");
        tooth(P, 1'b1, 0, 256, P, 1'b1, 0, "sync");
        for (int i = 1; i <= 34; i++)
            tooth(i == 34 ? 2 * P : P, 1'b1, i * 256, i == 34 ? 512 : 256, P, 1'b1, 0,
                  $sformatf("rev1_%0d", i));
        tooth(P, 1'b1, 0, 256, P, 1'b1, 0, "rev2_0");

        // Extra edge half way through the gap.
        for (int i = 1; i <= 34; i++)
            tooth(P, 1'b1, i * 256, i == 34 ? 512 : 256, P, 1'b1, 0, $sformatf("rev2_%0d", i));
        tooth(P, 1'b0, 0, 0, 0, 1'b0, 1, "extra_edge");
        resync(0, 1);

        // Tooth 10 missing reads as a premature gap.
        for (int i = 1; i <= 9; i++)
            tooth(i == 9 ? 2 * P : P, 1'b1, i * 256, 256, P, 1'b1, 1, $sformatf("pre_drop%0d", i));
        tooth(P, 1'b0, 0, 0, 0, 1'b0, 2, "drop10");
        resync(12, 2);

        // 20-clk glitch 30 clks after tooth 1.
        tooth(30, 1'b1, 256, 256, P, 1'b1, 2, "pre_glitch");
        crank = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch.trigger", 32'(ev.trigger), 0);
        repeat (16) @(negedge clk);
        crank = 1'b0;
        repeat (50) @(negedge clk);
        tooth(P, 1'b1, 512, 256, P, 1'b1, 2, "post_glitch");

        // Gap edge landing exactly on the timeout, then a real stall.
        for (int i = 3; i <= 34; i++)
            tooth(i == 34 ? 5000 : P, 1'b1, i * 256, i == 34 ? 512 : 256, P, 1'b1, 2,
                  $sformatf("rev_c%0d", i));
        tooth(P, 1'b1, 0, 256, 2500, 1'b1, 2, "coincident");
        tooth(5003, 1'b1, 256, 256, P, 1'b1, 2, "pre_stall");
        check("stall_m1.synced", 32'(ev.synced), 1);
        @(negedge clk);
        check("stall.synced", 32'(ev.synced), 0);
        check("stall.period", ev.tooth_period, 0);
        check("stall.trigger", 32'(ev.trigger), 0);

        // Restart and accelerate over two revolutions, then reset mid-rev.
        tooth(P, 1'b0, 0, 0, 0, 1'b0, 2, "restart");
        tooth(2 * P, 1'b0, 0, 0, 0, 1'b0, 2, "restart_seek");
        for (int k = 0; k <= 74; k++)
            tooth(accel_w(k + 1), 1'b1, (k % 35) * 256, (k % 35) == 34 ? 512 : 256,
                  accel_p(k), 1'b1, 2, $sformatf("accel%0d", k));
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrev_reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loss counter saturation on the short-blanking instance: seek, sync, lose.
        sat_edge(10);
        for (int n = 1; n <= 256; n++) begin
            sat_edge(16);
            sat_edge(25);
            sat_edge(10);
            if (n == 1) check("sat.loss1", 32'(ev2.sync_loss_cnt), 1);
            if (n == 255) check("sat.loss255", 32'(ev2.sync_loss_cnt), 255);
        end
        check("sat.loss256", 32'(ev2.sync_loss_cnt), 255);
        check("sat.synced", 32'(ev2.synced), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
